mem_bank_pipe: RTL and testbench
================================

Name: mem_bank_pipe

Overview:
- Four-bank interleaved main-memory model downstream of the direct-mapped cache controller.
- Consumes the controller's mem_addr/mem_data_in/mem_wr/mem_rd and returns mem_data_out with fixed 2-cycle read latency, so line fills and write-backs can issue one word per cycle to rotating banks.
- Each bank is busy for several cycles after an access. A stall is raised when a request targets a busy bank.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- LAT, 2, read latency in cycles from the accept cycle to the data cycle.
- BUSY, 4, cycles a bank is occupied, including the accept cycle.
- WORDS, 32768, words of backing store (index = addr[15:1]).

Ports:
- clk, in, 1, system clock; all state changes on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- addr, in, ADDR_W, byte address; bank = addr[2:1].
- data_in, in, DATA_W, write data.
- wr, in, 1, write request.
- rd, in, 1, read request.
- data_out, out, DATA_W, read data; valid only when rd_valid=1.
- rd_valid, out, 1, data_out carries the read accepted LAT cycles earlier.
- stall, out, 1, request not accepted this cycle; requester must hold.
- busy, out, 4, per-bank busy flags.
- err, out, 1, illegal request this cycle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset values: all bank counters 0, so busy=0000. Read pipeline valids cleared: rd_valid=0, data_out=0. err and stall read 0 (no request is held during reset). The memory array is not cleared by rst.
- Request = rd|wr.
- err is combinational. It is 1 when both rd and wr are 1, or when addr[0]=1 with a request. An erroring request is never accepted and changes no state; stall=0 for it.
- stall is combinational: request & ~err & busy[addr[2:1]].
- Accept = request & ~err & ~stall, sampled at the rising edge ending cycle C.
- Bank counters:
  - On accept, the selected bank's counter loads BUSY-1.
  - A nonzero counter decrements by 1 each cycle.
  - busy[b] = (counter[b] != 0).
  - The same bank can accept again in cycle C+BUSY.
  - Distinct banks accept back-to-back, one per cycle, with no stall.
- Counter at 1 in cycle C: the bank is still busy in C; it reads 0 and is free in C+1.
- Write: the array word addr[15:1] is updated with data_in at the accept edge. There is no response pulse; rd_valid is not asserted.
- Read: the array is sampled at the accept edge into a LAT-deep shift pipeline of {valid, data}. In cycle C+LAT, rd_valid=1 and data_out = word. Otherwise data_out=0 and rd_valid=0.
- Read ordering: a read returns the contents as of its accept edge. A write to the same word is blocked by bank busy for BUSY cycles, so there is no read/write hazard within the pipeline.
- Pipeline throughput: one read in flight per stage. Consecutive reads to different banks produce consecutive rd_valid cycles in issue order.
- Reset mid-operation: all in-flight reads are discarded (rd_valid stays 0 afterwards) and all counters are cleared. A write accepted on an edge where rst=1 is not performed; rst has priority over accept.
- Stalled or idle cycles shift a bubble (valid=0) through the pipeline.
- Constraint: LAT >= 1.
- Out-of-range: with WORDS < 2^(ADDR_W-1), index bits above log2(WORDS) are ignored (wrap-around).

Test Plan:
- Write 0xBEEF to 0x0010 in cycle 0, read 0x0010 in cycle 4 -> stall=0 both times; rd_valid=1 and data_out=0xBEEF in cycle 6; busy=0001 during cycles 1-3.
- Reads to 0x0000, 0x0002, 0x0004, 0x0006 in cycles 0-3 (pre-loaded 0x1111..0x4444) -> no stall; rd_valid=1 in cycles 2-5 with 0x1111, 0x2222, 0x3333, 0x4444 in order.
- Read 0x0008 in cycle 0, then hold read 0x0000 from cycle 1 -> stall=1 in cycles 1-3; accepted in cycle 4; data in cycle 6.
- rd=wr=1 at 0x0020, then rd with addr=0x0021 -> err=1, stall=0, busy unchanged, no rd_valid, array unchanged.
- Read issued in cycle 0, rst=1 in cycle 1 -> rd_valid=0 in cycle 2; busy=0000 from cycle 2.
- Write 0x1234 at 0x0006 in cycle 0, read 0x0006 held from cycle 1 -> stall in cycles 1-3; rd_valid in cycle 6 with 0x1234.

Source files
------------

// File: rtl/mem_bank_pipe.sv
// Four-bank interleaved main-memory model with a fixed-latency read pipeline.
// A bank stays busy for BUSY cycles after it accepts; requests to a busy bank stall.
module mem_bank_pipe #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LAT    = 2,
  parameter int BUSY   = 4,
  parameter int WORDS  = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(BUSY + 1);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [CNT_W-1:0]  cnt [4];
  stage_t            pipe [LAT];
  logic [DATA_W-1:0] mem [WORDS];

  logic             req;
  logic             accept;
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;

  assign req    = rd | wr;
  assign bank   = addr[2:1];
  assign idx    = addr[IDX_W:1];
  assign err    = (rd & wr) | (addr[0] & req);
  assign stall  = req & ~err & busy[bank];
  assign accept = req & ~err & ~stall;

  always_comb begin
    busy = '0;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt[b] != '0);
    end
  end

  // A bank only accepts while its counter is zero, so load and decrement never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && bank == b[1:0]) begin
          cnt[b] <= CNT_W'(BUSY - 1);
        end else if (cnt[b] != '0) begin
          cnt[b] <= cnt[b] - 1'b1;
        end
      end
    end
  end

  // NOTE: the backing store has no reset; rst only gates the write enable so a
  // write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && accept && wr) begin
      mem[idx] <= data_in;
    end
  end

  // NOTE: non-blocking assignments make every stage shift from its pre-edge value,
  // and the read samples the array contents as of the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= (accept && rd) ? stage_t'{valid: 1'b1, data: mem[idx]} : '0;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rd_valid = pipe[LAT-1].valid;
  assign data_out = pipe[LAT-1].data;

endmodule

// File: tb/tb_mem_bank_pipe.sv
// Directed, table-driven bench for mem_bank_pipe: one table row per clock cycle,
// followed by a hand-written reset-in-flight sequence.
module tb_mem_bank_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        err;
    logic [3:0]  busy;
    logic        rv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [$];

  mem_bank_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic s, input logic e, input logic [3:0] b,
                     input logic v, input logic [15:0] o);
    vec_t x;
    x.rd = r; x.wr = w; x.addr = a; x.din = d;
    x.stall = s; x.err = e; x.busy = b; x.rv = v; x.dout = o;
    vecs.push_back(x);
  endtask

  task automatic idle(input logic [3:0] b, input logic v, input logic [15:0] o);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, b, v, o);
  endtask

  initial begin
    // Preload four banks back-to-back, plus 0x0008 on bank 0 once it frees.
    add(0, 1, 16'h0000, 16'h1111, 0, 0, 4'b0000, 0, 16'h0000);
    add(0, 1, 16'h0002, 16'h2222, 0, 0, 4'b0001, 0, 16'h0000);
    add(0, 1, 16'h0004, 16'h3333, 0, 0, 4'b0011, 0, 16'h0000);
    add(0, 1, 16'h0006, 16'h4444, 0, 0, 4'b0111, 0, 16'h0000);
    add(0, 1, 16'h0008, 16'h8888, 0, 0, 4'b1110, 0, 16'h0000);
    idle(4'b1101, 0, 16'h0000);
    idle(4'b1001, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    // Interleaved reads, one per cycle, returning in order two cycles later.
    add(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    add(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
    add(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0011, 1, 16'h1111);
    add(1, 0, 16'h0006, 16'h0000, 0, 0, 4'b0111, 1, 16'h2222);
    idle(4'b1110, 1, 16'h3333);
    idle(4'b1100, 1, 16'h4444);
    idle(4'b1000, 0, 16'h0000);
    idle(4'b0000, 0, 16'h0000);
    // Write then read same bank exactly BUSY cycles later.
    add(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    add(1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    idle(4'b0001, 1, 16'hBEEF);
    idle(4'b0001, 0, 16'h0000);
    // Read 0x0008, then a held read to the same bank stalls three cycles.
    add(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    add(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 0, 16'h0000);
    add(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 1, 16'h8888);
    add(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 0, 16'h0000);
    add(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    idle(4'b0001, 1, 16'h1111);
    idle(4'b0001, 0, 16'h0000);
    // Write 0x1234 to bank 3 then a held read of the same word.
    add(0, 1, 16'h0006, 16'h1234, 0, 0, 4'b0000, 0, 16'h0000);
    add(1, 0, 16'h0006, 16'h0000, 1, 0, 4'b1000, 0, 16'h0000);
    add(1, 0, 16'h0006, 16'h0000, 1, 0, 4'b1000, 0, 16'h0000);
    add(1, 0, 16'h0006, 16'h0000, 1, 0, 4'b1000, 0, 16'h0000);
    add(1, 0, 16'h0006, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    idle(4'b1000, 0, 16'h0000);
    idle(4'b1000, 1, 16'h1234);
    idle(4'b1000, 0, 16'h0000);
    // Illegal requests: never stall, never accepted, never touch state.
    add(0, 1, 16'h0020, 16'h5A5A, 0, 0, 4'b0000, 0, 16'h0000);
    add(1, 1, 16'h0020, 16'hFFFF, 0, 1, 4'b0001, 0, 16'h0000);
    add(1, 0, 16'h0023, 16'h0000, 0, 1, 4'b0001, 0, 16'h0000);
    add(0, 1, 16'h0025, 16'hFFFF, 0, 1, 4'b0001, 0, 16'h0000);
    idle(4'b0000, 0, 16'h0000);
    add(1, 0, 16'h0020, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
    idle(4'b0001, 0, 16'h0000);
    idle(4'b0001, 1, 16'h5A5A);
    idle(4'b0001, 0, 16'h0000);

    rst = 1'b1;
    drive(0, 0, 16'h0000, 16'h0000);
    step();
    step();
    @(negedge clk);
    check("reset busy", 32'(busy), 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset err", 32'(err), 32'h0);
    step();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      @(negedge clk);
      check($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].stall));
      check($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      check($sformatf("row%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
      step();
    end

    // Reset with a read in flight and a write presented on the reset edge.
    drive(1, 0, 16'h0002, 16'h0000);
    @(negedge clk);
    check("rst seq issue stall", 32'(stall), 32'h0);
    step();
    rst = 1'b1;
    drive(0, 1, 16'h0020, 16'hDEAD);
    @(negedge clk);
    check("rst seq busy before", 32'(busy), 32'h2);
    step();
    rst = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("rst seq rd_valid", 32'(rd_valid), 32'h0);
    check("rst seq data_out", 32'(data_out), 32'h0);
    check("rst seq busy after", 32'(busy), 32'h0);
    step();
    drive(1, 0, 16'h0020, 16'h0000);
    @(negedge clk);
    check("rst seq flushed", 32'(rd_valid), 32'h0);
    check("rst seq read stall", 32'(stall), 32'h0);
    step();
    drive(0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("rst seq busy bank0", 32'(busy), 32'h1);
    step();
    @(negedge clk);
    check("rst seq readback valid", 32'(rd_valid), 32'h1);
    check("rst seq write dropped", 32'(data_out), 32'h5A5A);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
